// File: rtl/my_signals_pkg.sv
// rtl/my_signals_pkg.sv - shared bus state type and data widths
package my_signals_pkg;

    localparam int BUS_DATA_W = 32;
    localparam int BUS_BE_W   = 4;

    typedef enum logic [1:0] {
        BUS_IDLE,
        BUS_BUSY,
        BUS_RESP
    } bus_state_t;

endpackage

// File: rtl/bus_timeout_cnt.sv
// rtl/bus_timeout_cnt.sv - wait-cycle counter flagging a hung slave access
module bus_timeout_cnt #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt;

    // Holding at LAST keeps the counter from wrapping if the caller leaves en high.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = (cnt == LAST);

endmodule

// File: rtl/riscv_bus_ic.sv
// rtl/riscv_bus_ic.sv - single-master, N-slave interconnect with region decode and bus timeout
module riscv_bus_ic
    import my_signals_pkg::*;
#(
    parameter int          SLAVES      = 4,
    parameter int          REGION_BITS = 8,
    parameter int          TIMEOUT     = 255,
    parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         m_req_i,
    input  logic                         m_we_i,
    input  logic [BUS_BE_W-1:0]          m_be_i,
    input  logic [31:0]                  m_addr_i,
    input  logic [BUS_DATA_W-1:0]        m_wd_i,
    output logic [BUS_DATA_W-1:0]        m_rd_o,
    output logic                         m_ready_o,
    output logic [SLAVES-1:0]            s_req_o,
    output logic                         s_we_o,
    output logic [BUS_BE_W-1:0]          s_be_o,
    output logic [31:0]                  s_addr_o,
    output logic [BUS_DATA_W-1:0]        s_wd_o,
    input  logic [BUS_DATA_W*SLAVES-1:0] s_rd_i,
    input  logic [SLAVES-1:0]            s_ready_i,
    output logic                         err_o,
    output logic [31:0]                  err_addr_o
);

    localparam logic [31:0] OFFSET_MASK = 32'hFFFF_FFFF >> REGION_BITS;

    if (SLAVES < 1 || (REGION_BITS < 31 && SLAVES > (1 << REGION_BITS))) begin : g_bad_slaves
        $error("riscv_bus_ic: SLAVES must be in 1..2**REGION_BITS");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("riscv_bus_ic: TIMEOUT must be at least 1");
    end

    bus_state_t              state, state_nxt;
    logic [REGION_BITS-1:0]  idx;
    logic                    mapped;
    logic [SLAVES-1:0]       req_oh;
    logic [SLAVES-1:0]       sel_oh;
    logic                    slave_ready;
    logic                    expired;
    logic [BUS_DATA_W-1:0]   rd_mux;
    logic [31:0]             addr_q;

    always_comb begin
        idx         = m_addr_i[31 -: REGION_BITS];
        mapped      = 33'(idx) < 33'(SLAVES);
        req_oh      = '0;
        rd_mux      = '0;
        for (int k = 0; k < SLAVES; k++) begin
            req_oh[k] = (33'(idx) == 33'(k));
            if (sel_oh[k]) begin
                rd_mux = s_rd_i[BUS_DATA_W*k +: BUS_DATA_W];
            end
        end
        // Only the addressed slave may complete the access.
        slave_ready = |(s_ready_i & sel_oh);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            BUS_IDLE: if (m_req_i) state_nxt = mapped ? BUS_BUSY : BUS_RESP;
            BUS_BUSY: if (slave_ready || expired) state_nxt = BUS_RESP;
            BUS_RESP: state_nxt = BUS_IDLE;
            default:  state_nxt = BUS_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= BUS_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    bus_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk_i),
        .rst     (rst_i),
        .clr     (state == BUS_IDLE),
        .en      (state == BUS_BUSY),
        .expired (expired)
    );

    // Response flops are loaded on the way into BUS_RESP so they are valid during it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s_req_o    <= '0;
            s_we_o     <= 1'b0;
            s_be_o     <= '0;
            s_addr_o   <= '0;
            s_wd_o     <= '0;
            m_ready_o  <= 1'b0;
            err_o      <= 1'b0;
            m_rd_o     <= '0;
            err_addr_o <= '0;
            addr_q     <= '0;
            sel_oh     <= '0;
        end else begin
            m_ready_o <= 1'b0;
            err_o     <= 1'b0;
            case (state)
                BUS_IDLE: begin
                    if (m_req_i) begin
                        s_we_o   <= m_we_i;
                        s_be_o   <= m_be_i;
                        s_addr_o <= m_addr_i & OFFSET_MASK;
                        s_wd_o   <= m_wd_i;
                        addr_q   <= m_addr_i;
                        sel_oh   <= req_oh;
                        if (mapped) begin
                            s_req_o <= req_oh;
                        end else begin
                            m_ready_o  <= 1'b1;
                            err_o      <= 1'b1;
                            m_rd_o     <= ERR_DATA;
                            err_addr_o <= m_addr_i;
                        end
                    end
                end
                BUS_BUSY: begin
                    if (slave_ready) begin
                        s_req_o   <= '0;
                        m_ready_o <= 1'b1;
                        m_rd_o    <= rd_mux;
                    end else if (expired) begin
                        s_req_o    <= '0;
                        m_ready_o  <= 1'b1;
                        err_o      <= 1'b1;
                        m_rd_o     <= ERR_DATA;
                        err_addr_o <= addr_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/riscv_bus_ic.md
# riscv_bus_ic

Parametrised single-master, N-slave memory interconnect between `riscv_lsu` and the memory/peripheral devices, replacing the LSU's point-to-point connection to `ext_mem`.
- Decodes the top address bits to select one slave and forwards the request with registered outputs.
- Waits for that slave's ready and returns read data to the LSU.
- Terminates unmapped or hung accesses with an error response and a bus timeout, so the core never stalls forever.

## Interface
Parameters:
- `SLAVES`, 4: number of slave ports, 1..2**`REGION_BITS`.
- `REGION_BITS`, 8: address bits [31:32-`REGION_BITS`] that form the slave index.
- `TIMEOUT`, 255: maximum number of cycles spent waiting for a slave's ready, ≥1.
- `ERR_DATA`, 32'hDEAD_BEEF: read data returned on an error.

Ports:
- `clk_i` in 1: the single clock; all logic is on the rising edge.
- `rst_i` in 1: synchronous, active-high reset.
- `m_req_i` in 1: LSU request; held high until `m_ready_o`.
- `m_we_i` in 1: write enable.
- `m_be_i` in 4: byte enables.
- `m_addr_i` in 32: byte address.
- `m_wd_i` in 32: write data.
- `m_rd_o` out 32: read data.
- `m_ready_o` out 1: one-cycle completion pulse.
- `s_req_o` out `SLAVES`: one-hot request.
- `s_we_o` out 1: write enable, broadcast to all slaves.
- `s_be_o` out 4: byte enables, broadcast to all slaves.
- `s_addr_o` out 32: slave offset, i.e. the address with the region bits zeroed.
- `s_wd_o` out 32: write data, broadcast to all slaves.
- `s_rd_i` in 32*`SLAVES`: flattened read data; slave k occupies [32k+31:32k].
- `s_ready_i` in `SLAVES`: per-slave ready.
- `err_o` out 1: error pulse, coincident with `m_ready_o`.
- `err_addr_o` out 32: address of the last failed access.

## Operation
- FSM states: `BUS_IDLE`, `BUS_BUSY`, `BUS_RESP`.
- **`BUS_IDLE`, no request:** stays in `BUS_IDLE` while `m_req_i`=0.
- **`BUS_IDLE`, request accepted:** on `m_req_i`=1, latch we/be/addr/wd and compute idx = `m_addr_i`[31:32-`REGION_BITS`].
  - idx < `SLAVES`: go to `BUS_BUSY`, set `s_req_o`[idx]=1, clear the timeout counter.
  - idx ≥ `SLAVES`: go to `BUS_RESP` with error set.
- **`BUS_BUSY`, slave ready:** `s_ready_i`[idx]=1 → capture `s_rd_i` slice idx into the read register, clear `s_req_o`, go to `BUS_RESP` with no error.
- **`BUS_BUSY`, timeout:** counter == `TIMEOUT`-1 with no ready → clear `s_req_o`, go to `BUS_RESP` with error.
- **`BUS_BUSY`, otherwise:** increment the counter.
- **`BUS_BUSY`, simultaneous ready and timeout:** ready wins.
- **`BUS_BUSY`, other slaves:** ready from slaves other than idx is ignored.
- **`BUS_RESP`:**
  - `m_ready_o`=1 for exactly one cycle.
  - `m_rd_o` = captured data, or `ERR_DATA` on error; it holds that value until the next `BUS_RESP`.
  - On error: `err_o`=1 and `err_addr_o` ← latched address.
  - Next state is always `BUS_IDLE`. `m_req_i` is not sampled in `BUS_RESP`.
- **Writes:** take the same path; the read register is loaded even on writes and its content is don't-care.
- **Unmapped-write side effects:** an unmapped write never asserts any `s_req_o` bit.
- **Counter width:** $clog2(`TIMEOUT`+1); it cannot wrap, because it is cleared on entry to `BUS_BUSY`.
- **Master contract:** the master drops or renews `m_req_i` in the cycle after `m_ready_o`. `m_req_i`=1 in `BUS_IDLE` is always treated as a new transaction.

## Timing
- **Reset values:**
  - state `BUS_IDLE`.
  - `s_req_o`=0; `s_we_o`=0, `s_be_o`=0, `s_addr_o`=0, `s_wd_o`=0.
  - `m_ready_o`=0, `err_o`=0.
  - `m_rd_o`=0, `err_addr_o`=0.
  - counter=0.
- **Mapped access:**
  - request sampled in `BUS_IDLE` at cycle 0 → `s_req_o` high from cycle 1.
  - slave ready in cycle k (k≥1) → `m_ready_o` in cycle k+1.
  - Minimum latency is 2 cycles.
- **Unmapped access:** request at cycle 0 → `m_ready_o`/`err_o` in cycle 1.
- **Timeout:** with `s_req_o` first high in cycle 1 and no ready, the error response occurs in cycle `TIMEOUT`+1.
- **Throughput:** back-to-back transactions give at most one completion every 3 cycles (IDLE→BUSY→RESP).
- **Reset mid-transaction:** reset in any state returns the block to `BUS_IDLE` on the next edge. `s_req_o` drops, and no `m_ready_o` or `err_o` is issued for the aborted access.

## Structure
- Add to `my_signals_pkg`:
  - `bus_state_t` enum {`BUS_IDLE`, `BUS_BUSY`, `BUS_RESP`};
  - constant `BUS_DATA_W`=32;
  - constant `BUS_BE_W`=4.
- Sub-module `bus_timeout_cnt` (parameter `TIMEOUT`): clear, enable, expired flag.
- Parameter checks in an initial block: `SLAVES` ≤ 2**`REGION_BITS`, and `TIMEOUT` ≥ 1.

## Test plan
- **Mapped read:** `SLAVES`=4; read 0x0000_0010; slave 0 ready in cycle 1 with data 0x1234_5678 → `m_ready_o` in cycle 2, `m_rd_o`=0x1234_5678, `err_o`=0.
- **Mapped write:** write 0x0100_0020, be=4'b0011, wd=0xCAFE_F00D; slave 1 ready after 3 cycles → `s_req_o`=4'b0010, `s_addr_o`=0x0000_0020, `m_ready_o` in cycle 4, no other slave requested.
- **Unmapped access:** read 0xFF00_0004 → `m_ready_o` and `err_o` in cycle 1, `m_rd_o`=0xDEAD_BEEF, `err_addr_o`=0xFF00_0004, `s_req_o` stays 0.
- **Timeout and race:** `TIMEOUT`=8, slave 2 never ready → error response in cycle 9. Repeat with ready arriving exactly in cycle 8 → normal response, `err_o`=0.
- **Reset mid-access:** assert `rst_i` in cycle 2 of a `BUS_BUSY` access → `s_req_o`=0 next cycle, no `m_ready_o`; a later request is served normally.
- **Back-to-back:** two reads with `m_req_i` held continuously → completions 3 cycles apart with correct data each.
